// File: rtl/ps2_hex_entry.sv
// PS/2 keyboard receiver: Set-2 hex keys build a two-nibble entry,
// Enter commits it as an 8-bit value with a one-cycle strobe.
module ps2_hex_entry #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       enable,
  output logic [7:0] entry,
  output logic [7:0] value,
  output logic       value_valid,
  output logic       frame_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PAR,
    S_STOP
  } st_e;

  logic [1:0]            csync_q, dsync_q;
  logic [FILTER_LEN-1:0] hist_q, hist_d;
  logic                  filt_q, filt_d;
  logic                  fall, din;
  st_e                   st_q, st_d;
  logic [2:0]            bcnt_q, bcnt_d;
  logic [7:0]            sh_q, sh_d;
  logic                  par_q, par_d;
  logic [TW-1:0]         to_q, to_d;
  logic                  bvld_q, bvld_d;
  logic [7:0]            byte_q, byte_d;
  logic                  err_q, err_d;
  logic                  ext_q, ext_d;
  logic                  brk_q, brk_d;
  logic [7:0]            entry_q, entry_d;
  logic [7:0]            value_q, value_d;
  logic                  vv_q, vv_d;
  logic [4:0]            hx;

  function automatic logic [4:0] hex_lu(input logic [7:0] c);
    logic [4:0] r;
    r = 5'd0;
    case (c)
      8'h45: r = 5'h10;
      8'h16: r = 5'h11;
      8'h1E: r = 5'h12;
      8'h26: r = 5'h13;
      8'h25: r = 5'h14;
      8'h2E: r = 5'h15;
      8'h36: r = 5'h16;
      8'h3D: r = 5'h17;
      8'h3E: r = 5'h18;
      8'h46: r = 5'h19;
      8'h1C: r = 5'h1A;
      8'h32: r = 5'h1B;
      8'h21: r = 5'h1C;
      8'h23: r = 5'h1D;
      8'h24: r = 5'h1E;
      8'h2B: r = 5'h1F;
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  // Level flips only once the whole sample history agrees
  always_comb begin
    hist_d = {hist_q[FILTER_LEN-2:0], csync_q[1]};
    filt_d = filt_q;
    if (hist_q == '0) filt_d = 1'b0;
    else if (&hist_q) filt_d = 1'b1;
  end

  assign fall = filt_q & (hist_q == '0);
  assign din  = dsync_q[1];

  always_comb begin
    st_d   = st_q;
    bcnt_d = bcnt_q;
    sh_d   = sh_q;
    par_d  = par_q;
    bvld_d = 1'b0;
    byte_d = byte_q;
    err_d  = 1'b0;
    to_d   = (st_q == S_IDLE) ? '0 : to_q + TW'(1);
    if (fall) begin
      to_d = '0;
      case (st_q)
        S_IDLE: begin
          if (!din) begin
            st_d   = S_DATA;
            bcnt_d = 3'd0;
          end else begin
            err_d = 1'b1;
          end
        end
        S_DATA: begin
          sh_d   = {din, sh_q[7:1]};
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) st_d = S_PAR;
        end
        S_PAR: begin
          par_d = din;
          st_d  = S_STOP;
        end
        default: begin
          st_d = S_IDLE;
          if (din && (^{sh_q, par_q})) begin
            bvld_d = 1'b1;
            byte_d = sh_q;
          end else begin
            err_d = 1'b1;
          end
        end
      endcase
    end else if (st_q != S_IDLE && to_q == TW'(TIMEOUT_CYCLES - 1)) begin
      st_d  = S_IDLE;
      err_d = 1'b1;
      to_d  = '0;
    end
  end

  assign hx = hex_lu(byte_q);

  always_comb begin
    ext_d   = ext_q;
    brk_d   = brk_q;
    entry_d = entry_q;
    value_d = value_q;
    vv_d    = 1'b0;
    if (bvld_q) begin
      unique case (1'b1)
        (byte_q == 8'hE0): ext_d = 1'b1;
        (byte_q == 8'hF0): brk_d = 1'b1;
        default: begin
          ext_d = 1'b0;
          brk_d = 1'b0;
          if (!ext_q && !brk_q && enable) begin
            unique case (1'b1)
              hx[4]: entry_d = {entry_q[3:0], hx[3:0]};
              (byte_q == 8'h66): entry_d = 8'h00;
              (byte_q == 8'h5A): begin
                value_d = entry_q;
                vv_d    = 1'b1;
                entry_d = 8'h00;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      csync_q <= 2'b11;
      dsync_q <= 2'b11;
      hist_q  <= '1;
      filt_q  <= 1'b1;
      st_q    <= S_IDLE;
      bcnt_q  <= 3'd0;
      sh_q    <= 8'h00;
      par_q   <= 1'b0;
      to_q    <= '0;
      bvld_q  <= 1'b0;
      byte_q  <= 8'h00;
      err_q   <= 1'b0;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      entry_q <= 8'h00;
      value_q <= 8'h00;
      vv_q    <= 1'b0;
    end else begin
      csync_q <= {csync_q[0], ps2_clk};
      dsync_q <= {dsync_q[0], ps2_data};
      hist_q  <= hist_d;
      filt_q  <= filt_d;
      st_q    <= st_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      to_q    <= to_d;
      bvld_q  <= bvld_d;
      byte_q  <= byte_d;
      err_q   <= err_d;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      entry_q <= entry_d;
      value_q <= value_d;
      vv_q    <= vv_d;
    end
  end

  assign entry       = entry_q;
  assign value       = value_q;
  assign value_valid = vv_q;
  assign frame_error = err_q;

endmodule

// File: tb/tb_ps2_hex_entry.sv
// Randomized scoreboard bench for ps2_hex_entry with a keystroke-level
// reference model; a monitor compares DUT events against queued expectations.
module tb_ps2_hex_entry;

  localparam int TMO = 50000;
  localparam int H   = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       en = 1'b1;
  logic [7:0] entry, value;
  logic       value_valid, frame_error;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_entry_q[$];
  logic [7:0] exp_val_q[$];
  int         exp_err_q[$];

  logic [7:0] m_entry = 8'h00;
  bit         m_ext = 1'b0;
  bit         m_brk = 1'b0;
  logic [7:0] prev_entry = 8'h00;

  logic [7:0] hexcode [16] = '{8'h45, 8'h16, 8'h1E, 8'h26,
                               8'h25, 8'h2E, 8'h36, 8'h3D,
                               8'h3E, 8'h46, 8'h1C, 8'h32,
                               8'h21, 8'h23, 8'h24, 8'h2B};

  ps2_hex_entry #(
    .FILTER_LEN(4),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clk),
    .reset_n(rst_n),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .enable(en),
    .entry(entry),
    .value(value),
    .value_valid(value_valid),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Keystroke-level model of what one clean byte does to the entry
  task automatic model_byte(input logic [7:0] b);
    int dig;
    logic [7:0] nxt;
    if (b == 8'hE0) begin
      m_ext = 1'b1;
      return;
    end
    if (b == 8'hF0) begin
      m_brk = 1'b1;
      return;
    end
    if (!m_ext && !m_brk && en) begin
      dig = -1;
      for (int i = 0; i < 16; i++)
        if (hexcode[i] == b) dig = i;
      nxt = m_entry;
      if (dig >= 0) nxt = 8'((m_entry * 16 + dig) % 256);
      else if (b == 8'h66) nxt = 8'h00;
      else if (b == 8'h5A) begin
        exp_val_q.push_back(m_entry);
        nxt = 8'h00;
      end
      if (nxt != m_entry) exp_entry_q.push_back(nxt);
      m_entry = nxt;
    end
    m_ext = 1'b0;
    m_brk = 1'b0;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    tick(H);
    ps2_clk = 1'b0;
    tick(H);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input bit bad_stop);
    if (bad_par || bad_stop) exp_err_q.push_back(1);
    else model_byte(b);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(~bad_stop);
    ps2_data = 1'b1;
    tick(24);
  endtask

  // Scoreboard monitor, sampling on the falling clock edge
  always @(negedge clk) begin
    if (value_valid) begin
      if (exp_val_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected value_valid: value %h", value);
      end else begin
        chk("value", value, exp_val_q.pop_front());
      end
    end
    if (frame_error) begin
      checks++;
      if (exp_err_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected frame_error: got 1 expected 0");
      end else begin
        void'(exp_err_q.pop_front());
      end
    end
    if (entry !== prev_entry) begin
      if (exp_entry_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected entry change: got %h was %h",
                 entry, prev_entry);
      end else begin
        chk("entry", entry, exp_entry_q.pop_front());
      end
      prev_entry = entry;
    end
  end

  initial begin
    int r;
    tick(3);
    chk("reset entry", entry, 8'h00);
    chk("reset value", value, 8'h00);
    chk("reset value_valid", {7'd0, value_valid}, 8'h00);
    chk("reset frame_error", {7'd0, frame_error}, 8'h00);
    rst_n = 1'b1;
    tick(10);

    send_frame(8'h16, 0, 0);
    send_frame(8'h2B, 0, 0);
    send_frame(8'h5A, 0, 0);
    send_frame(8'h16, 0, 0);
    send_frame(8'h1E, 0, 0);
    send_frame(8'h26, 0, 0);
    send_frame(8'h5A, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h16, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_frame(8'h16, 0, 0);
    send_frame(8'h16, 1, 0);
    send_frame(8'h16, 0, 1);
    send_frame(8'h2E, 0, 0);

    // Partial frame, then a silent line long enough to time out
    exp_err_q.push_back(1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    tick(TMO + 100);
    chk("timeout error seen", 8'(exp_err_q.size()), 8'd0);
    send_frame(8'h45, 0, 0);

    en = 1'b0;
    send_frame(8'h1C, 0, 0);
    send_frame(8'h5A, 0, 0);
    en = 1'b1;
    chk("entry after disabled", entry, m_entry);

    send_frame(8'h3D, 0, 0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    if (m_entry != 8'h00) exp_entry_q.push_back(8'h00);
    rst_n = 1'b0;
    m_entry = 8'h00;
    m_ext = 1'b0;
    m_brk = 1'b0;
    @(negedge clk);
    chk("midreset entry", entry, 8'h00);
    chk("midreset value", value, 8'h00);
    chk("midreset value_valid", {7'd0, value_valid}, 8'h00);
    chk("midreset frame_error", {7'd0, frame_error}, 8'h00);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    tick(4);
    rst_n = 1'b1;
    tick(10);
    send_frame(8'h16, 0, 0);

    for (int n = 0; n < 60; n++) begin
      en = ($urandom_range(0, 7) != 0);
      r = $urandom_range(0, 99);
      if (r < 50) send_frame(hexcode[$urandom_range(0, 15)], 0, 0);
      else if (r < 58) send_frame(8'h66, 0, 0);
      else if (r < 66) send_frame(8'h5A, 0, 0);
      else if (r < 74) send_frame(8'hE0, 0, 0);
      else if (r < 82) send_frame(8'hF0, 0, 0);
      else if (r < 90) send_frame(8'($urandom_range(0, 255)), 0, 0);
      else send_frame(hexcode[$urandom_range(0, 15)],
                      1'($urandom_range(0, 1)), 1'b1);
    end
    en = 1'b1;
    send_frame(8'h5A, 0, 0);
    tick(10);

    chk("final entry", entry, m_entry);
    chk("pending entry events", 8'(exp_entry_q.size()), 8'd0);
    chk("pending value events", 8'(exp_val_q.size()), 8'd0);
    chk("pending error events", 8'(exp_err_q.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
